lspc_vram_cpu_port: RTL

- CPU-side VRAM access port of the LSPC. Decodes the REG_VRAMADDR, REG_VRAMRW and REG_VRAMMOD writes and holds the current VRAM address, write data and modulo.
- Issues single write and prefetch-read requests to the slow (low 32K) or fast (upper) VRAM cycle generators. Captures the returned data and applies the post-access auto-increment.
- Sits directly upstream of the slow-cycle block: it drives VRAM_ADDR, VRAM_WRITE, REG_VRAMADDR_MSB and nVRAM_WRITE_REQ, and consumes VRAM_LOW_READ and the cycle acknowledge.

---
 rtl/lspc_vram_pkg.sv | 23 ++
 rtl/lspc_vram_cmd_slot.sv | 50 +++++
 rtl/lspc_vram_cpu_port.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lspc_vram_pkg.sv
// Shared definitions for the LSPC CPU-side VRAM port.
//   - register-select codes seen on REG_SEL
//   - access sequencer state encoding
//   - command record held in the one-deep command slot
package lspc_vram_pkg;

  localparam logic [1:0] REG_VRAMADDR = 2'd0;
  localparam logic [1:0] REG_VRAMRW   = 2'd1;
  localparam logic [1:0] REG_VRAMMOD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_INC      = 2'd2,
    ST_PREFETCH = 2'd3
  } vram_state_e;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] data;
  } vram_cmd_t;

endpackage

// File: rtl/lspc_vram_cmd_slot.sv
// One-deep command holding slot with overwrite semantics.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : store load_cmd (overwrites any held command)
//   load_cmd   : command to store
//   pop        : release the held command
//   full       : a command is held
//   cmd        : the held command
// A load in the same cycle as a pop wins, so a command arriving while the
// previous one is being dispatched is not lost.
module lspc_vram_cmd_slot
  import lspc_vram_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  vram_cmd_t load_cmd,
  input  logic      pop,
  output logic      full,
  output vram_cmd_t cmd
);

  logic      full_q, full_d;
  vram_cmd_t cmd_q, cmd_d;

  always_comb begin
    full_d = full_q;
    cmd_d  = cmd_q;
    if (load) begin
      full_d = 1'b1;
      cmd_d  = load_cmd;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      cmd_q  <= '0;
    end else begin
      full_q <= full_d;
      cmd_q  <= cmd_d;
    end
  end

  assign full = full_q;
  assign cmd  = cmd_q;

endmodule

// File: rtl/lspc_vram_cpu_port.sv
// CPU-side VRAM access port of the LSPC.
// Decodes VRAMADDR / VRAMRW / VRAMMOD register writes, sequences single
// write and prefetch-read accesses to the slow (MSB=0) or fast (MSB=1) VRAM
// cycle generators, and applies the post-write auto-increment.
// Ports:
//   CLK_24M, nRESET               : clock, asynchronous active-low reset
//   CPU_WR_STB/CPU_RD_STB/REG_SEL : CPU register strobes and select
//   CPU_DIN / CPU_DOUT            : CPU data in / registered read data
//   VRAM_LOW_READ/VRAM_HIGH_READ  : read words from slow / fast VRAM
//   SLOW_ACK / FAST_ACK           : cycle generator service pulses
//   VRAM_ADDR, REG_VRAMADDR_MSB   : word address and bank select
//   VRAM_WRITE                    : write data
//   nVRAM_WRITE_REQ/nVRAM_READ_REQ: active-low access requests
//   VRAMMOD                       : address modulo
//   BUSY                          : access in progress or command queued
module lspc_vram_cpu_port
  import lspc_vram_pkg::*;
#(
  parameter int          ADDR_W    = 15,
  parameter logic [15:0] RESET_MOD = 16'h0000
) (
  input  logic              CLK_24M,
  input  logic              nRESET,
  input  logic              CPU_WR_STB,
  input  logic              CPU_RD_STB,
  input  logic [1:0]        REG_SEL,
  input  logic [15:0]       CPU_DIN,
  output logic [15:0]       CPU_DOUT,
  input  logic [15:0]       VRAM_LOW_READ,
  input  logic [15:0]       VRAM_HIGH_READ,
  input  logic              SLOW_ACK,
  input  logic              FAST_ACK,
  output logic [ADDR_W-1:0] VRAM_ADDR,
  output logic              REG_VRAMADDR_MSB,
  output logic [15:0]       VRAM_WRITE,
  output logic              nVRAM_WRITE_REQ,
  output logic              nVRAM_READ_REQ,
  output logic [15:0]       VRAMMOD,
  output logic              BUSY
);

  vram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              msb_q, msb_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       mod_q, mod_d;
  logic [15:0]       latch_q, latch_d;
  logic [15:0]       dout_q, dout_d;
  logic              wr_req_n_q, wr_req_n_d;
  logic              rd_req_n_q, rd_req_n_d;

  logic              wr_mod, wr_cmd, active_ack;
  logic [15:0]       mod_eff;
  logic              slot_load, slot_pop, slot_full, dispatch;
  vram_cmd_t         slot_cmd, new_cmd, disp_cmd;

  assign wr_mod     = CPU_WR_STB && (REG_SEL == REG_VRAMMOD);
  assign wr_cmd     = CPU_WR_STB && ((REG_SEL == REG_VRAMADDR) || (REG_SEL == REG_VRAMRW));
  assign active_ack = msb_q ? FAST_ACK : SLOW_ACK;
  // A modulo write in the INC cycle must already steer that increment.
  assign mod_eff    = wr_mod ? CPU_DIN : mod_q;
  assign new_cmd    = '{sel: REG_SEL, data: CPU_DIN};

  // Commands arriving while an access runs are parked; an arrival in the
  // cycle a parked command is dispatched replaces it in the slot.
  assign slot_pop  = (state_q == ST_IDLE) && slot_full;
  assign slot_load = wr_cmd && ((state_q != ST_IDLE) || slot_full);
  assign dispatch  = (state_q == ST_IDLE) && (slot_full || wr_cmd);
  assign disp_cmd  = slot_full ? slot_cmd : new_cmd;

  lspc_vram_cmd_slot u_slot (
    .clk      (CLK_24M),
    .rst_n    (nRESET),
    .load     (slot_load),
    .load_cmd (new_cmd),
    .pop      (slot_pop),
    .full     (slot_full),
    .cmd      (slot_cmd)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    msb_d      = msb_q;
    wdata_d    = wdata_q;
    mod_d      = mod_q;
    latch_d    = latch_q;
    dout_d     = dout_q;
    wr_req_n_d = wr_req_n_q;
    rd_req_n_d = rd_req_n_q;

    if (wr_mod) mod_d = CPU_DIN;

    case (state_q)
      ST_IDLE: begin
        if (dispatch) begin
          if (disp_cmd.sel == REG_VRAMADDR) begin
            addr_d     = disp_cmd.data[ADDR_W-1:0];
            msb_d      = disp_cmd.data[ADDR_W];
            rd_req_n_d = 1'b0;
            state_d    = ST_PREFETCH;
          end else begin
            wdata_d    = disp_cmd.data;
            wr_req_n_d = 1'b0;
            state_d    = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (active_ack) begin
          wr_req_n_d = 1'b1;
          state_d    = ST_INC;
        end
      end
      ST_INC: begin
        // Bank select is untouched; the address wraps within its bank.
        addr_d     = addr_q + mod_eff[ADDR_W-1:0];
        rd_req_n_d = 1'b0;
        state_d    = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        if (active_ack) begin
          latch_d    = msb_q ? VRAM_HIGH_READ : VRAM_LOW_READ;
          rd_req_n_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reads use the registered (pre-write) values.
    if (CPU_RD_STB) begin
      case (REG_SEL)
        REG_VRAMADDR, REG_VRAMRW: dout_d = latch_q;
        REG_VRAMMOD:              dout_d = mod_q;
        default:                  dout_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      msb_q      <= 1'b0;
      wdata_q    <= 16'h0000;
      mod_q      <= RESET_MOD;
      latch_q    <= 16'h0000;
      dout_q     <= 16'h0000;
      wr_req_n_q <= 1'b1;
      rd_req_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      msb_q      <= msb_d;
      wdata_q    <= wdata_d;
      mod_q      <= mod_d;
      latch_q    <= latch_d;
      dout_q     <= dout_d;
      wr_req_n_q <= wr_req_n_d;
      rd_req_n_q <= rd_req_n_d;
    end
  end

  assign CPU_DOUT         = dout_q;
  assign VRAM_ADDR        = addr_q;
  assign REG_VRAMADDR_MSB = msb_q;
  assign VRAM_WRITE       = wdata_q;
  assign VRAMMOD          = mod_q;
  assign nVRAM_WRITE_REQ  = wr_req_n_q;
  assign nVRAM_READ_REQ   = rd_req_n_q;
  assign BUSY             = (state_q != ST_IDLE) || slot_full;

endmodule
